// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, opcode encodings and issue FSM state type
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational aluop/funct to ALU control code decode
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [3:0] code_o,
    output logic       illegal_o
);

    always_comb begin
        code_o    = ALU_AND;
        illegal_o = 1'b0;
        case (aluop_i)
            ALUOP_ADD: code_o = ALU_ADD;
            ALUOP_SUB: code_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: code_o = ALU_ADD;
                    FUNCT_SUB: code_o = ALU_SUB;
                    FUNCT_AND: code_o = ALU_AND;
                    FUNCT_OR:  code_o = ALU_OR;
                    default:   illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one request to a registered ALU and returns its result
// Optional macro ALU_ISSUE_ZERO_FLAG_EN adds the rsp_zero output.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_aluop,
    input  logic [5:0]    req_funct,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_ctrl,
    input  logic [DW-1:0] alu_result,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    ,
    output logic          rsp_zero
`endif
);

    state_e        state_q;
    logic [DW-1:0] alu_a_q;
    logic [DW-1:0] alu_b_q;
    logic [3:0]    alu_ctrl_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_err_q;
    logic          rsp_zero_q;
    logic [3:0]    dec_code;
    logic          dec_illegal;

    alu_op_decode u_decode (
        .aluop_i   (req_aluop),
        .funct_i   (req_funct),
        .code_o    (dec_code),
        .illegal_o (dec_illegal)
    );

    // ALU operands only move on a legal acceptance; an illegal request never disturbs them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= 4'd0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_zero_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (dec_illegal) begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                            rsp_zero_q <= 1'b0;
                            state_q    <= ST_RESP;
                        end else begin
                            alu_a_q    <= req_a;
                            alu_b_q    <= req_b;
                            alu_ctrl_q <= dec_code;
                            state_q    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state_q <= ST_CAPTURE;
                ST_CAPTURE: begin
                    rsp_data_q <= alu_result;
                    rsp_err_q  <= 1'b0;
                    rsp_zero_q <= (alu_result == '0);
                    state_q    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

`ifdef ALU_ISSUE_ZERO_FLAG_EN
    assign rsp_zero = rsp_zero_q;
`else
    logic unused_zero;
    assign unused_zero = rsp_zero_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl with a registered ALU model
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_aluop;
    logic [5:0]    req_funct;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic          rsp_zero;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_aluop  (req_aluop),
        .req_funct  (req_funct),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        ,
        .rsp_zero   (rsp_zero)
`endif
    );

    // External registered ALU: result follows the driven operands by one edge.
    always @(posedge clk) begin
        case (alu_ctrl)
            4'd0:    alu_result <= alu_a & alu_b;
            4'd1:    alu_result <= alu_a | alu_b;
            4'd2:    alu_result <= alu_a + alu_b;
            4'd6:    alu_result <= alu_a - alu_b;
            default: alu_result <= '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [5:0] fn,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_aluop = op; req_funct = fn; req_a = a; req_b = b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_aluop = 2'b00; req_funct = 6'd0; req_a = '0; req_b = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b exp 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
        checks++; if (alu_a !== 5'd0 || alu_b !== 5'd0) begin fails++; $display("FAIL reset_alu_ab: got %0d/%0d exp 0/0", alu_a, alu_b); end
        checks++; if (alu_ctrl !== 4'd0) begin fails++; $display("FAIL reset_alu_ctrl: got %0d exp 0", alu_ctrl); end
        checks++; if (rsp_data !== 5'd0 || rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp: got %0d/%b exp 0/0", rsp_data, rsp_err); end
    endtask

    task automatic test_legal_add();
        do_req(2'b00, 6'd0, 5'd7, 5'd5);
        checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL add_e1_state: got ready=%b valid=%b exp 0/0", req_ready, rsp_valid); end
        checks++; if (alu_ctrl !== 4'd2 || alu_a !== 5'd7 || alu_b !== 5'd5) begin fails++; $display("FAIL add_drive: got ctrl=%0d a=%0d b=%0d exp 2/7/5", alu_ctrl, alu_a, alu_b); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL add_e2_valid: got %b exp 0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL add_e3_valid: got %b exp 1", rsp_valid); end
        checks++; if (rsp_data !== 5'd12 || rsp_err !== 1'b0) begin fails++; $display("FAIL add_data: got %0d err=%b exp 12 err=0", rsp_data, rsp_err); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL add_handshake: got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_sub_wrap();
        do_req(2'b10, 6'b100010, 5'd3, 5'd5);
        checks++; if (alu_ctrl !== 4'd6) begin fails++; $display("FAIL sub_ctrl: got %0d exp 6", alu_ctrl); end
        tick(); tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 5'd30) begin fails++; $display("FAIL sub_data: got valid=%b data=%0d exp 1/30", rsp_valid, rsp_data); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_illegal();
        do_req(2'b10, 6'b101010, 5'd9, 5'd9);
        checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL illegal_funct_valid: got %b exp 1", rsp_valid); end
        checks++; if (rsp_err !== 1'b1 || rsp_data !== 5'd0) begin fails++; $display("FAIL illegal_funct_rsp: got err=%b data=%0d exp 1/0", rsp_err, rsp_data); end
        checks++; if (alu_ctrl !== 4'd6 || alu_a !== 5'd3 || alu_b !== 5'd5) begin fails++; $display("FAIL illegal_alu_hold: got ctrl=%0d a=%0d b=%0d exp 6/3/5", alu_ctrl, alu_a, alu_b); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        do_req(2'b11, 6'b100000, 5'd1, 5'd1);
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 5'd0) begin fails++; $display("FAIL illegal_aluop: got valid=%b err=%b data=%0d exp 1/1/0", rsp_valid, rsp_err, rsp_data); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_req(2'b10, 6'b100100, 5'h1C, 5'h0F);
        tick(); tick();
        req_aluop = 2'b00; req_a = 5'd1; req_b = 5'd1; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 5'h0C || rsp_err !== 1'b0) begin fails++; $display("FAIL bp_hold[%0d]: got valid=%b data=%0h exp 1/0c", i, rsp_valid, rsp_data); end
            checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %b exp 0", i, req_ready); end
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_back_to_back();
        req_aluop = 2'b00; req_funct = 6'd0; req_a = 5'd1; req_b = 5'd2;
        req_valid = 1'b1; rsp_ready = 1'b1;
        tick(); tick(); tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 5'd3) begin fails++; $display("FAIL b2b_first: got valid=%b data=%0d exp 1/3", rsp_valid, rsp_data); end
        req_a = 5'd4; req_b = 5'd4;
        tick();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL b2b_gap: got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
        tick();
        checks++; if (req_ready !== 1'b0 || alu_a !== 5'd4) begin fails++; $display("FAIL b2b_accept: got ready=%b alu_a=%0d exp 0/4", req_ready, alu_a); end
        req_valid = 1'b0;
        tick(); tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 5'd8) begin fails++; $display("FAIL b2b_second: got valid=%b data=%0d exp 1/8", rsp_valid, rsp_data); end
        tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_reset_capture();
        do_req(2'b00, 6'd0, 5'd10, 5'd10);
        tick();
        rst = 1'b1; rsp_ready = 1'b1; tick(); rst = 1'b0; rsp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_a !== 5'd0) begin fails++; $display("FAIL rstcap_state: got ready=%b valid=%b alu_a=%0d exp 1/0/0", req_ready, rsp_valid, alu_a); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstcap_no_rsp[%0d]: got %b exp 0", i, rsp_valid); end
            tick();
        end
        req_aluop = 2'b00; req_a = 5'd5; req_b = 5'd5; req_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; req_valid = 1'b0;
        checks++; if (req_ready !== 1'b1 || alu_a !== 5'd0) begin fails++; $display("FAIL rst_priority: got ready=%b alu_a=%0d exp 1/0", req_ready, alu_a); end
        do_req(2'b10, 6'b100101, 5'd1, 5'd2);
        tick(); tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 5'd3) begin fails++; $display("FAIL rstcap_or: got valid=%b data=%0d exp 1/3", rsp_valid, rsp_data); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

`ifdef ALU_ISSUE_ZERO_FLAG_EN
    task automatic test_zero_flag();
        do_req(2'b01, 6'd0, 5'd9, 5'd9);
        tick(); tick();
        checks++; if (rsp_zero !== 1'b1 || rsp_data !== 5'd0) begin fails++; $display("FAIL zero_sub: got zero=%b data=%0d exp 1/0", rsp_zero, rsp_data); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        do_req(2'b00, 6'd0, 5'd1, 5'd1);
        tick(); tick();
        checks++; if (rsp_zero !== 1'b0 || rsp_data !== 5'd2) begin fails++; $display("FAIL zero_add: got zero=%b data=%0d exp 0/2", rsp_zero, rsp_data); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        do_req(2'b11, 6'd0, 5'd0, 5'd0);
        checks++; if (rsp_zero !== 1'b0 || rsp_err !== 1'b1) begin fails++; $display("FAIL zero_illegal: got zero=%b err=%b exp 0/1", rsp_zero, rsp_err); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_legal_add();
        test_sub_wrap();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_capture();
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
